// File: rtl/fetch_decode_if.sv
// Handshake bundle between the fetch/decode controller and the 8-bit datapath
// plus its instruction memory.
interface fetch_decode_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic [PC_W-1:0] instrAddr;
    logic [15:0]     instrData;
    logic            zeroFlag;
    logic [7:0]      dataIM;
    logic            selB;
    logic [2:0]      aluOp;
    logic            loadA;
    logic            loadB;
    logic            halted;

    // Controller side.
    modport master (
        input  run, instrData, zeroFlag,
        output instrAddr, dataIM, selB, aluOp, loadA, loadB, halted
    );

    // Datapath / instruction memory side.
    modport slave (
        output run, instrData, zeroFlag,
        input  instrAddr, dataIM, selB, aluOp, loadA, loadB, halted
    );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode controller: fetches 16-bit instructions by pc, latches them into
// IR and drives the datapath controls, handling jumps and halt.
//
// state  | meaning
// FETCH  | instrAddr = pc presented to memory; wait here while run = 0
// LATCH  | memory data captured into IR; decoded controls settle
// EXEC   | load strobes fire for ALU class; pc advances or jumps
// HALTED | HALT executed; parked until reset
module fetch_decode #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_decode_if.master bus
);
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        LATCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } stateT;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_JMP  = 2'b01;
    localparam logic [1:0] CLS_JZ   = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    stateT           state, stateNext;
    logic [PC_W-1:0] pc, pcNext;
    logic [15:0]     ir, irNext;

    logic [1:0]      irClass;
    logic            isAlu;
    logic [PC_W-1:0] pcInc;
    logic [PC_W-1:0] target;
    logic            inExec;

    assign irClass = ir[15:14];
    assign isAlu   = (irClass == CLS_ALU);
    assign pcInc   = pc + PC_W'(1);
    assign target  = ir[PC_W-1:0];

    // State, program counter and instruction register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            ir    <= irNext;
        end
    end

    // Sequencing: FETCH -> LATCH -> EXEC -> FETCH, with jump/halt resolution in EXEC.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        irNext    = ir;
        case (state)
            FETCH: begin
                if (bus.run) stateNext = LATCH;
            end
            LATCH: begin
                irNext    = bus.instrData;
                stateNext = EXEC;
            end
            EXEC: begin
                stateNext = FETCH;
                case (irClass)
                    CLS_ALU:  pcNext = pcInc;
                    CLS_JMP:  pcNext = target;
                    CLS_JZ:   pcNext = bus.zeroFlag ? target : pcInc;
                    CLS_HALT: stateNext = HALTED;
                    default:  pcNext = pcInc;
                endcase
            end
            HALTED: begin
                stateNext = HALTED;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // Decoded controls come straight from IR, so they hold steady from EXEC
    // until the next LATCH. Strobes are masked by rst_n so a reset landing in
    // EXEC drops them in that same cycle.
    assign inExec        = (state == EXEC) && rst_n;
    assign bus.instrAddr = pc;
    assign bus.dataIM    = isAlu ? ir[7:0] : 8'h00;
    assign bus.selB      = isAlu & ir[13];
    assign bus.aluOp     = isAlu ? ir[12:10] : 3'd0;
    assign bus.loadA     = inExec & isAlu & ir[8];
    assign bus.loadB     = inExec & isAlu & ir[9];
    assign bus.halted    = (state == HALTED);
endmodule
